// File: rtl/stream_word_packer_pkg.sv
// Shared definitions for the 72-bit packed beat: field offsets and packer state encoding.
// The FIFO-side consumer imports the same offsets to unpack beats.
package stream_word_packer_pkg;

    localparam int unsigned LO_LSB       = 0;
    localparam int unsigned HI_LSB       = 32;
    localparam int unsigned HI_VALID_BIT = 64;
    localparam int unsigned LAST_BIT     = 65;
    localparam int unsigned TAG_LSB      = 66;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOW  = 1'b1
    } pack_state_e;

endpackage

// File: rtl/stream_word_packer_idle_flush_timer.sv
// Idle timer for a held low word: counts enabled cycles, saturates at the limit,
// and raises flush_due while the limit is reached. FLUSH_CYCLES of 0 never flushes.
module idle_flush_timer #(
    parameter int unsigned FLUSH_CYCLES = 256,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_flush_due_c
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(FLUSH_CYCLES - 1);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Saturating at LIMIT lets a blocked flush fire as soon as the output slot frees
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_flush_due_c = (FLUSH_CYCLES != 0) && i_enable && (r_cnt == LIMIT);

endmodule

// File: rtl/stream_word_packer.sv
// Packs pairs of 32-bit stream words into 72-bit tagged beats for the BRAM FIFO,
// flushing a lone low word on last or after an idle timeout.
module stream_word_packer
    import stream_word_packer_pkg::*;
#(
    parameter int unsigned IN_WIDTH     = 32,
    parameter int unsigned TAG_WIDTH    = 6,
    parameter int unsigned FLUSH_CYCLES = 256,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [IN_WIDTH-1:0]                 ss_data,
    input  logic                                ss_last,
    input  logic                                ss_valid,
    output logic                                ss_ready,
    output logic [2*IN_WIDTH+2+TAG_WIDTH-1:0]   ms_data,
    output logic                                ms_valid,
    input  logic                                ms_ready,
    output logic                                busy
);

    localparam int unsigned OUT_WIDTH = 2 * IN_WIDTH + 2 + TAG_WIDTH;

    pack_state_e            r_state;
    pack_state_e            w_next_state;
    logic [IN_WIDTH-1:0]    r_lo;
    logic [TAG_WIDTH-1:0]   r_tag;

    logic                   w_slot_free;
    logic                   w_acc;
    logic                   w_flush_due;
    logic                   w_emit;
    logic                   w_lo_load;
    logic                   w_tag_inc;
    logic [OUT_WIDTH-1:0]   w_beat;

    assign w_slot_free = !ms_valid || ms_ready;
    assign ss_ready    = !reset && w_slot_free;
    assign w_acc       = ss_valid && ss_ready;
    assign busy        = (r_state == ST_LOW);

    idle_flush_timer #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_idle_flush_timer (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_acc || (w_next_state == ST_IDLE)),
        .i_enable      (r_state == ST_LOW),
        .o_flush_due_c (w_flush_due)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acc && !ss_last) begin
                    w_next_state = ST_LOW;
                end
            end
            ST_LOW: begin
                if (w_acc || (w_flush_due && w_slot_free)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Beat assembly; an accepted word always takes priority over a timeout flush
    always_comb begin
        w_emit    = 1'b0;
        w_lo_load = 1'b0;
        w_tag_inc = 1'b0;
        w_beat    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (ss_last) begin
                        w_emit    = 1'b1;
                        w_tag_inc = 1'b1;
                        w_beat    = {r_tag, 1'b1, 1'b0, {IN_WIDTH{1'b0}}, ss_data};
                    end else begin
                        w_lo_load = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (w_acc) begin
                    w_emit    = 1'b1;
                    w_tag_inc = ss_last;
                    w_beat    = {r_tag, ss_last, 1'b1, ss_data, r_lo};
                end else if (w_flush_due && w_slot_free) begin
                    w_emit    = 1'b1;
                    w_beat    = {r_tag, 1'b0, 1'b0, {IN_WIDTH{1'b0}}, r_lo};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lo     <= '0;
            r_tag    <= '0;
            ms_data  <= '0;
            ms_valid <= 1'b0;
        end else begin
            if (w_lo_load) begin
                r_lo <= ss_data;
            end
            if (w_tag_inc) begin
                r_tag <= r_tag + TAG_WIDTH'(1);
            end
            if (w_emit) begin
                ms_data  <= w_beat;
                ms_valid <= 1'b1;
            end else if (ms_ready) begin
                ms_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_word_packer.sv
// Randomized and directed bench for stream_word_packer against a word-level
// reference model (held word + idle-cycle count + output slot occupancy).
module tb_stream_word_packer;
    import stream_word_packer_pkg::*;

    localparam int unsigned IW = 32;
    localparam int unsigned TW = 6;
    localparam int unsigned OW = 2 * IW + 2 + TW;
    localparam int unsigned FC = 4;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] ss_data;
    logic          ss_last;
    logic          ss_valid;
    logic          ss_ready;
    logic [OW-1:0] ms_data;
    logic          ms_valid;
    logic          ms_ready;
    logic          busy;

    always #5 clk = ~clk;

    stream_word_packer #(
        .IN_WIDTH     (IW),
        .TAG_WIDTH    (TW),
        .FLUSH_CYCLES (FC),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ss_data  (ss_data),
        .ss_last  (ss_last),
        .ss_valid (ss_valid),
        .ss_ready (ss_ready),
        .ms_data  (ms_data),
        .ms_valid (ms_valid),
        .ms_ready (ms_ready),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [OW-1:0] make_beat(input int tag, input bit last, input bit hv,
                                                 input logic [IW-1:0] hi, input logic [IW-1:0] lo);
        logic [OW-1:0] b;
        b = '0;
        b[LO_LSB +: IW]   = lo;
        b[HI_LSB +: IW]   = hv ? hi : '0;
        b[HI_VALID_BIT]   = hv;
        b[LAST_BIT]       = last;
        b[TAG_LSB +: TW]  = TW'(tag);
        return b;
    endfunction

    // Reference model state
    bit            m_hold;
    logic [IW-1:0] m_lo;
    int            m_tag;
    int            m_idle;
    bit            m_ovalid;
    logic [OW-1:0] m_odata;
    bit            m_acc;
    int            n_words_in;
    int            n_words_out;
    logic [OW-1:0] got_q[$];
    bit            obs_valid;
    bit            obs_busy;

    task automatic model_step();
        bit            slot_free;
        bit            emit;
        logic [OW-1:0] beat;
        emit  = 0;
        beat  = '0;
        m_acc = 0;
        if (reset) begin
            m_hold = 0; m_lo = '0; m_tag = 0; m_idle = 0; m_ovalid = 0; m_odata = '0;
            return;
        end
        slot_free = !m_ovalid || ms_ready;
        m_acc     = ss_valid && slot_free;
        if (m_acc) begin
            n_words_in++;
            if (m_hold) begin
                beat   = make_beat(m_tag, ss_last, 1, ss_data, m_lo);
                emit   = 1;
                m_hold = 0;
                if (ss_last) m_tag = (m_tag + 1) % 64;
            end else if (ss_last) begin
                beat  = make_beat(m_tag, 1, 0, '0, ss_data);
                emit  = 1;
                m_tag = (m_tag + 1) % 64;
            end else begin
                m_hold = 1;
                m_lo   = ss_data;
            end
            m_idle = 0;
        end else if (m_hold) begin
            if (m_idle >= int'(FC) - 1 && slot_free) begin
                beat   = make_beat(m_tag, 0, 0, '0, m_lo);
                emit   = 1;
                m_hold = 0;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
        if (emit) begin
            m_ovalid = 1;
            m_odata  = beat;
        end else if (ms_ready) begin
            m_ovalid = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("ss_ready", OW'(ss_ready), OW'(!reset && (!m_ovalid || ms_ready)));
        chk("ms_valid", OW'(ms_valid), OW'(m_ovalid));
        chk("ms_data", ms_data, m_odata);
        chk("busy", OW'(busy), OW'(m_hold));
        obs_valid = ms_valid;
        obs_busy  = busy;
        if (ms_valid && ms_ready && !reset) begin
            got_q.push_back(ms_data);
            n_words_out += ms_data[HI_VALID_BIT] ? 2 : 1;
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IW-1:0] d, input bit last);
        bit done;
        done     = 0;
        ss_data  = d;
        ss_last  = last;
        ss_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            cycle();
            done = m_acc;
        end
        if (!done) chk("send_timeout", OW'(done), OW'(1));
        ss_valid = 1'b0;
        ss_last  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int pv;
        reset = 1'b1; ss_data = '0; ss_last = 1'b0; ss_valid = 1'b0; ms_ready = 1'b1;
        m_hold = 0; m_lo = '0; m_tag = 0; m_idle = 0; m_ovalid = 0; m_odata = '0; m_acc = 0;
        n_words_in = 0; n_words_out = 0; obs_valid = 0; obs_busy = 0;
        #1;
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_ms_valid", OW'(ms_valid), OW'(0));
        chk("rst_ms_data", ms_data, '0);
        chk("rst_busy", OW'(busy), OW'(0));

        // Paired words
        got_q.delete();
        send(32'hA000_0001, 0); send(32'hA000_0002, 0);
        send(32'hA000_0003, 0); send(32'hA000_0004, 1);
        cycle(); cycle();
        chk("pair_count", OW'(got_q.size()), OW'(2));
        if (got_q.size() == 2) begin
            chk("pair_beat0", got_q[0], make_beat(0, 0, 1, 32'hA000_0002, 32'hA000_0001));
            chk("pair_beat1", got_q[1], make_beat(0, 1, 1, 32'hA000_0004, 32'hA000_0003));
        end

        // Odd packet (tag now 1)
        got_q.delete();
        send(32'hB000_0001, 0); send(32'hB000_0002, 0); send(32'hB000_0003, 1);
        cycle(); cycle();
        chk("odd_count", OW'(got_q.size()), OW'(2));
        if (got_q.size() == 2) begin
            chk("odd_beat0", got_q[0], make_beat(1, 0, 1, 32'hB000_0002, 32'hB000_0001));
            chk("odd_beat1", got_q[1], make_beat(1, 1, 0, '0, 32'hB000_0003));
        end
        chk("odd_idle", OW'(busy), OW'(0));

        // Idle flush
        got_q.delete();
        send(32'hC000_0001, 0);
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            cycle();
            if (obs_valid) n = i;
        end
        chk("flush_latency", OW'(n), OW'(5));
        chk("flush_busy", OW'(obs_busy), OW'(0));
        send(32'hC000_0002, 1);
        cycle(); cycle();
        chk("flush_count", OW'(got_q.size()), OW'(2));
        if (got_q.size() == 2) begin
            chk("flush_beat0", got_q[0], make_beat(2, 0, 0, '0, 32'hC000_0001));
            chk("flush_beat1", got_q[1], make_beat(2, 1, 0, '0, 32'hC000_0002));
        end

        // Backpressure
        got_q.delete();
        ms_ready = 1'b0;
        send(32'hF000_0001, 1);
        ss_data = 32'hF000_0002; ss_last = 1'b1; ss_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (m_acc) chk("bp_accepted", OW'(1), OW'(0));
        end
        chk("bp_ready", OW'(ss_ready), OW'(0));
        chk("bp_data", ms_data, make_beat(3, 1, 0, '0, 32'hF000_0001));
        ms_ready = 1'b1;
        send(32'hF000_0002, 1);
        cycle(); cycle();
        chk("bp_count", OW'(got_q.size()), OW'(2));
        if (got_q.size() == 2) begin
            chk("bp_beat0", got_q[0], make_beat(3, 1, 0, '0, 32'hF000_0001));
            chk("bp_beat1", got_q[1], make_beat(4, 1, 0, '0, 32'hF000_0002));
        end

        // Tag wrap
        do_reset();
        got_q.delete();
        for (int k = 0; k < 65; k++) send(IW'(k + 32'h100), 1);
        cycle(); cycle();
        chk("wrap_count", OW'(got_q.size()), OW'(65));
        if (got_q.size() == 65) begin
            chk("wrap_tag63", got_q[63], make_beat(63, 1, 0, '0, 32'h13F));
            chk("wrap_tag0", got_q[64], make_beat(0, 1, 0, '0, 32'h140));
        end

        // Reset mid-packet
        send(32'hD000_0001, 0);
        do_reset();
        chk("midrst_valid", OW'(ms_valid), OW'(0));
        chk("midrst_busy", OW'(busy), OW'(0));
        got_q.delete();
        send(32'hE000_0001, 0); send(32'hE000_0002, 1);
        cycle(); cycle();
        chk("midrst_count", OW'(got_q.size()), OW'(1));
        if (got_q.size() == 1)
            chk("midrst_beat", got_q[0], make_beat(0, 1, 1, 32'hE000_0002, 32'hE000_0001));

        // Randomized traffic with varying density and backpressure
        do_reset();
        n_words_in  = 0;
        n_words_out = 0;
        pv = 90;
        for (int i = 0; i < 900; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0: pv = 90;
                    1: pv = 30;
                    default: pv = 5;
                endcase
            end
            ss_valid = ($urandom_range(0, 99) < pv);
            ss_last  = ($urandom_range(0, 4) == 0);
            ss_data  = $urandom;
            ms_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end
        ss_valid = 1'b0;
        ss_last  = 1'b0;
        ms_ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        chk("word_count", OW'(n_words_out), OW'(n_words_in));
        chk("drain_idle", OW'(busy), OW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
